// File: rtl/tt_um_jleugeri_ttt_processor.sv
// Token-threshold processor: saturating good/bad token counters,
// fires a tstart pulse on threshold, tstop after a duration or bad abort.
module tt_um_jleugeri_ttt_processor #(
    parameter int NEW_TOKENS_BITS = 4,
    parameter int TOKENS_BITS     = 8,
    parameter int DURATION_BITS   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NEW_TOKENS_BITS-1:0] new_good_tokens,
    input  logic [NEW_TOKENS_BITS-1:0] new_bad_tokens,
    input  logic                       cfg_we,
    input  logic [1:0]                 cfg_sel,
    input  logic [TOKENS_BITS-1:0]     cfg_data,
    output logic [1:0]                 tstartstop,
    output logic                       hot,
    output logic [TOKENS_BITS-1:0]     good_tokens,
    output logic [TOKENS_BITS-1:0]     bad_tokens
);

    // Two guard bits: one for the sign, one so that max + max delta
    // cannot overflow the signed sum before it is clamped.
    localparam int SW = TOKENS_BITS + 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [TOKENS_BITS-1:0]     good_q, good_d;
    logic [TOKENS_BITS-1:0]     bad_q, bad_d;
    logic [DURATION_BITS-1:0]   rem_q, rem_d;
    logic [1:0]                 tss_q, tss_d;
    logic [TOKENS_BITS-1:0]     gthr_q, gthr_d;
    logic [TOKENS_BITS-1:0]     bthr_q, bthr_d;
    logic [DURATION_BITS-1:0]   dur_q, dur_d;
    logic [TOKENS_BITS-1:0]     g_next;
    logic [TOKENS_BITS-1:0]     b_next;
    logic [DURATION_BITS-1:0]   dur_eff;

    function automatic logic [TOKENS_BITS-1:0] sat_add(
        input logic [TOKENS_BITS-1:0]     cur,
        input logic [NEW_TOKENS_BITS-1:0] delta
    );
        logic signed [SW-1:0] s;
        s = $signed({2'b00, cur})
          + $signed({{(SW-NEW_TOKENS_BITS){delta[NEW_TOKENS_BITS-1]}}, delta});
        if (s[SW-1]) begin
            sat_add = '0;
        end else if (s[SW-2]) begin
            sat_add = '1;
        end else begin
            sat_add = s[TOKENS_BITS-1:0];
        end
    endfunction

    assign g_next  = sat_add(good_q, new_good_tokens);
    assign b_next  = sat_add(bad_q, new_bad_tokens);
    assign dur_eff = (dur_q == '0) ? DURATION_BITS'(1) : dur_q;

    // Next-state, counter and pulse logic; config writes land after the FSM step.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        rem_d   = rem_q;
        tss_d   = 2'b00;
        gthr_d  = gthr_q;
        bthr_d  = bthr_q;
        dur_d   = dur_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    good_d = g_next;
                    bad_d  = b_next;
                    if (g_next >= gthr_q && b_next < bthr_q) begin
                        state_d = ACTIVE;
                        tss_d   = 2'b01;
                        rem_d   = dur_eff;
                    end
                end
                ACTIVE: begin
                    if (rem_q == DURATION_BITS'(1) || b_next >= bthr_q) begin
                        state_d = IDLE;
                        tss_d   = 2'b10;
                        good_d  = '0;
                        bad_d   = '0;
                        rem_d   = '0;
                    end else begin
                        rem_d  = rem_q - DURATION_BITS'(1);
                        good_d = g_next;
                        bad_d  = b_next;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (cfg_we) begin
            case (cfg_sel)
                2'd0:    gthr_d = cfg_data;
                2'd1:    bthr_d = cfg_data;
                2'd2:    dur_d  = cfg_data[DURATION_BITS-1:0];
                default: ;
            endcase
        end
    end

    // State and config registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            good_q  <= '0;
            bad_q   <= '0;
            rem_q   <= '0;
            tss_q   <= 2'b00;
            gthr_q  <= '1;
            bthr_q  <= '1;
            dur_q   <= DURATION_BITS'(1);
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            rem_q   <= rem_d;
            tss_q   <= tss_d;
            gthr_q  <= gthr_d;
            bthr_q  <= bthr_d;
            dur_q   <= dur_d;
        end
    end

    assign tstartstop  = tss_q;
    assign hot         = (state_q == ACTIVE);
    assign good_tokens = good_q;
    assign bad_tokens  = bad_q;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_processor.sv
// Bench for the token-threshold processor: per-step scoreboard
// against a behavioural model, plus scenario checks.
module tb_tt_um_jleugeri_ttt_processor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] new_good_tokens = '0;
    logic [3:0] new_bad_tokens = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_sel = '0;
    logic [7:0] cfg_data = '0;
    logic [1:0] tstartstop;
    logic       hot;
    logic [7:0] good_tokens;
    logic [7:0] bad_tokens;

    tt_um_jleugeri_ttt_processor dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .new_good_tokens (new_good_tokens),
        .new_bad_tokens  (new_bad_tokens),
        .cfg_we          (cfg_we),
        .cfg_sel         (cfg_sel),
        .cfg_data        (cfg_data),
        .tstartstop      (tstartstop),
        .hot             (hot),
        .good_tokens     (good_tokens),
        .bad_tokens      (bad_tokens)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] tss;
        logic       hot;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_step = 0;

    bit   m_act;
    int   m_good, m_bad, m_rem, m_gthr, m_bthr, m_dur;
    int   m_tss;

    function automatic int sat(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Behavioural model of one clock, expectation queued, DUT compared after the edge.
    task automatic step_full(input bit r, input bit e, input int dg, input int db,
                             input bit we, input int sel, input int data);
        int   g, b;
        exp_t x;
        reset           = r;
        enable          = e;
        new_good_tokens = 4'(dg);
        new_bad_tokens  = 4'(db);
        cfg_we          = we;
        cfg_sel         = 2'(sel);
        cfg_data        = 8'(data);
        if (r) begin
            m_act = 0; m_good = 0; m_bad = 0; m_rem = 0; m_tss = 0;
            m_gthr = 255; m_bthr = 255; m_dur = 1;
        end else begin
            m_tss = 0;
            if (e) begin
                g = sat(m_good + dg);
                b = sat(m_bad + db);
                if (!m_act) begin
                    m_good = g; m_bad = b;
                    if (g >= m_gthr && b < m_bthr) begin
                        m_act = 1; m_tss = 1;
                        m_rem = (m_dur == 0) ? 1 : m_dur;
                    end
                end else if (m_rem == 1 || b >= m_bthr) begin
                    m_act = 0; m_tss = 2;
                    m_good = 0; m_bad = 0; m_rem = 0;
                end else begin
                    m_rem = m_rem - 1;
                    m_good = g; m_bad = b;
                end
            end
            if (we) begin
                if (sel == 0) m_gthr = data;
                else if (sel == 1) m_bthr = data;
                else if (sel == 2) m_dur = data;
            end
        end
        x.tss = 2'(m_tss); x.hot = m_act; x.g = 8'(m_good); x.b = 8'(m_bad);
        q.push_back(x);
        @(posedge clk);
        #1;
        n_step++;
        x = q.pop_front();
        n_cmp++;
        if ({tstartstop, hot, good_tokens, bad_tokens} !== {x.tss, x.hot, x.g, x.b}) begin
            n_err++;
            $display("FAIL sb step %0d: got tss=%b hot=%b g=%0d b=%0d, want tss=%b hot=%b g=%0d b=%0d",
                     n_step, tstartstop, hot, good_tokens, bad_tokens, x.tss, x.hot, x.g, x.b);
        end
    endtask

    task automatic step(input int dg, input int db);
        step_full(0, 1, dg, db, 0, 0, 0);
    endtask

    task automatic idle_step(input int dg);
        step_full(0, 0, dg, dg, 0, 0, 0);
    endtask

    task automatic cfg(input int sel, input int data);
        step_full(0, 0, 0, 0, 1, sel, data);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step_full(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset(2);
        n_cmp++;
        if ({hot, tstartstop, good_tokens, bad_tokens} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_outs: got hot=%b tss=%b g=%0d b=%0d, want all 0",
                     hot, tstartstop, good_tokens, bad_tokens);
        end
        step(7, 0);
        n_cmp++;
        if (tstartstop !== 2'b00 || hot !== 1'b0 || good_tokens !== 8'd7) begin
            n_err++;
            $display("FAIL reset_thr: got tss=%b hot=%b g=%0d, want 00 0 7",
                     tstartstop, hot, good_tokens);
        end
    endtask

    task automatic test_fire_timeout();
        do_reset(1);
        cfg(0, 5); cfg(1, 3); cfg(2, 2);
        step(3, 0);
        n_cmp++;
        if (tstartstop !== 2'b00) begin
            n_err++; $display("FAIL t2_early: got tss=%b, want 00", tstartstop);
        end
        step(3, 0);
        n_cmp++;
        if (tstartstop !== 2'b01 || hot !== 1'b1 || good_tokens !== 8'd6) begin
            n_err++;
            $display("FAIL t2_start: got tss=%b hot=%b g=%0d, want 01 1 6",
                     tstartstop, hot, good_tokens);
        end
        step(0, 0);
        n_cmp++;
        if (tstartstop !== 2'b00 || hot !== 1'b1) begin
            n_err++; $display("FAIL t2_mid: got tss=%b hot=%b, want 00 1", tstartstop, hot);
        end
        step(0, 0);
        n_cmp++;
        if (tstartstop !== 2'b10 || hot !== 1'b0 || good_tokens !== 8'd0 || bad_tokens !== 8'd0) begin
            n_err++;
            $display("FAIL t2_stop: got tss=%b hot=%b g=%0d b=%0d, want 10 0 0 0",
                     tstartstop, hot, good_tokens, bad_tokens);
        end
    endtask

    task automatic test_bad_abort();
        do_reset(1);
        cfg(0, 2); cfg(1, 3); cfg(2, 10);
        step(2, 0);
        step(0, 4);
        n_cmp++;
        if (tstartstop !== 2'b10 || hot !== 1'b0 || bad_tokens !== 8'd0) begin
            n_err++;
            $display("FAIL t3_abort: got tss=%b hot=%b b=%0d, want 10 0 0",
                     tstartstop, hot, bad_tokens);
        end
    endtask

    task automatic test_saturation();
        int starts;
        starts = 0;
        do_reset(1);
        cfg(0, 255); cfg(2, 200);
        for (int i = 0; i < 40; i++) begin
            step(7, 0);
            if (tstartstop == 2'b01) starts++;
        end
        n_cmp++;
        if (good_tokens !== 8'd255 || starts !== 1 || hot !== 1'b1) begin
            n_err++;
            $display("FAIL t4_clamp_hi: got g=%0d starts=%0d hot=%b, want 255 1 1",
                     good_tokens, starts, hot);
        end
        do_reset(1);
        step(2, 0);
        step(-8, 0);
        n_cmp++;
        if (good_tokens !== 8'd0) begin
            n_err++; $display("FAIL t4_clamp_lo: got g=%0d, want 0", good_tokens);
        end
    endtask

    task automatic test_enable_cfg();
        do_reset(1);
        for (int i = 0; i < 10; i++) idle_step(7);
        n_cmp++;
        if (good_tokens !== 8'd0 || bad_tokens !== 8'd0 || tstartstop !== 2'b00) begin
            n_err++;
            $display("FAIL t5_gate: got g=%0d b=%0d tss=%b, want 0 0 00",
                     good_tokens, bad_tokens, tstartstop);
        end
        step_full(0, 1, 1, 0, 1, 0, 1);
        n_cmp++;
        if (tstartstop !== 2'b00 || good_tokens !== 8'd1) begin
            n_err++;
            $display("FAIL t5_oldcfg: got tss=%b g=%0d, want 00 1", tstartstop, good_tokens);
        end
        step(0, 0);
        n_cmp++;
        if (tstartstop !== 2'b01) begin
            n_err++; $display("FAIL t5_newcfg: got tss=%b, want 01", tstartstop);
        end
        do_reset(1);
        cfg(3, 0);
        step(7, 0);
        n_cmp++;
        if (tstartstop !== 2'b00 || hot !== 1'b0) begin
            n_err++; $display("FAIL t5_sel3: got tss=%b hot=%b, want 00 0", tstartstop, hot);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1);
        cfg(0, 1); cfg(2, 0);
        step(1, 0);
        n_cmp++;
        if (tstartstop !== 2'b01) begin
            n_err++; $display("FAIL b2b_start: got tss=%b, want 01", tstartstop);
        end
        step(5, 0);
        n_cmp++;
        if (tstartstop !== 2'b10 || good_tokens !== 8'd0) begin
            n_err++;
            $display("FAIL b2b_stop: got tss=%b g=%0d, want 10 0", tstartstop, good_tokens);
        end
        step(1, 0);
        n_cmp++;
        if (tstartstop !== 2'b01 || hot !== 1'b1) begin
            n_err++; $display("FAIL b2b_restart: got tss=%b hot=%b, want 01 1", tstartstop, hot);
        end
        do_reset(1);
        cfg(0, 0); cfg(1, 0);
        for (int i = 0; i < 4; i++) step(3, 0);
        n_cmp++;
        if (hot !== 1'b0 || tstartstop !== 2'b00) begin
            n_err++; $display("FAIL zero_thr: got hot=%b tss=%b, want 0 00", hot, tstartstop);
        end
    endtask

    task automatic test_reset_active();
        do_reset(1);
        cfg(0, 1); cfg(2, 10);
        step(1, 0);
        cfg(2, 1);
        step(0, 0);
        n_cmp++;
        if (hot !== 1'b1 || tstartstop !== 2'b00) begin
            n_err++; $display("FAIL t6_durwrite: got hot=%b tss=%b, want 1 00", hot, tstartstop);
        end
        do_reset(1);
        n_cmp++;
        if (hot !== 1'b0 || tstartstop !== 2'b00) begin
            n_err++; $display("FAIL t6_reset: got hot=%b tss=%b, want 0 00", hot, tstartstop);
        end
        step(7, 0);
        n_cmp++;
        if (tstartstop !== 2'b00 || good_tokens !== 8'd7) begin
            n_err++;
            $display("FAIL t6_defaults: got tss=%b g=%0d, want 00 7", tstartstop, good_tokens);
        end
    endtask

    initial begin
        test_reset();
        test_fire_timeout();
        test_bad_abort();
        test_saturation();
        test_enable_cfg();
        test_back_to_back();
        test_reset_active();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
